// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: qualified serial bits are framed into WIDTH-bit words
// and handed out through a registered valid/ready slot with sticky overrun on dropped words.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             si,
  input  logic             si_valid,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_next;
  logic             accept;
  logic             word_done;
  logic             slot_free;

  if (LSB_FIRST) begin : g_lsb_first
    assign sh_next = {si, sh[WIDTH-1:1]};
  end else begin : g_msb_first
    assign sh_next = {sh[WIDTH-2:0], si};
  end

  assign accept    = si_valid & ~clr;
  assign word_done = accept && (bit_cnt == CW'(WIDTH - 1));
  assign slot_free = ~pout_valid | pout_ready;

  // Shift/framing path: keeps running even while the output slot is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (si_valid) begin
      sh      <= sh_next;
      bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
    end
  end

  // Output slot; a word completing while the slot is free loads without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pout       <= '0;
      pout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (clr) begin
        overrun <= 1'b0;
      end
      if (word_done) begin
        if (slot_free) begin
          pout       <= sh_next;
          pout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (pout_valid && pout_ready) begin
        pout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: LSB-first and MSB-first instances share stimulus and are
// compared against a bit-queue reference model plus fixed expected words.
module tb_sipo_deser;

  localparam int W  = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n, clr, si, si_valid, pout_ready;
  logic [W-1:0]  d_pout [2];
  logic          d_pv   [2];
  logic [CW-1:0] d_cnt  [2];
  logic          d_ov   [2];

  int total = 0;
  int bad   = 0;

  // reference model state (index 0 = LSB-first, 1 = MSB-first)
  bit         q[$];
  logic [7:0] m_pout  [2];
  bit         m_valid [2];
  bit         m_ovr   [2];

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .si(si), .si_valid(si_valid),
    .pout(d_pout[0]), .pout_valid(d_pv[0]), .pout_ready(pout_ready),
    .bit_cnt(d_cnt[0]), .overrun(d_ov[0]));

  sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .si(si), .si_valid(si_valid),
    .pout(d_pout[1]), .pout_valid(d_pv[1]), .pout_ready(pout_ready),
    .bit_cnt(d_cnt[1]), .overrun(d_ov[1]));

  function automatic logic [7:0] pack(input bit msb);
    logic [7:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) w[W-1-i] = q[i];
      else     w[i]     = q[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < 2; k++) begin
      m_pout[k] = '0; m_valid[k] = 1'b0; m_ovr[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit done = 1'b0;
    logic [7:0] wrd [2];
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (clr) begin
      q.delete();
      m_ovr[0] = 1'b0; m_ovr[1] = 1'b0;
    end else if (si_valid) begin
      q.push_back(si);
      if (q.size() == W) begin
        done = 1'b1;
        wrd[0] = pack(1'b0);
        wrd[1] = pack(1'b1);
        q.delete();
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (done) begin
        if (!m_valid[k] || pout_ready) begin
          m_pout[k] = wrd[k]; m_valid[k] = 1'b1;
        end else begin
          m_ovr[k] = 1'b1;
        end
      end else if (m_valid[k] && pout_ready) begin
        m_valid[k] = 1'b0;
      end
    end
  endtask

  task automatic step(input bit b, input bit v, input bit rdy, input bit c);
    si = b; si_valid = v; pout_ready = rdy; clr = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input bit msb_order, input bit rdy_mid,
                           input bit rdy_last, input bit gaps);
    for (int i = 0; i < W; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        for (int j = 0; j < g; j++) step($urandom_range(0, 1), 1'b0, rdy_mid, 1'b0);
      end
      step(msb_order ? w[W-1-i] : w[i], 1'b1, (i == W-1) ? rdy_last : rdy_mid, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; si = 1'b0; si_valid = 1'b0; pout_ready = 1'b0;
    model_reset();
    #1;
    total++;
    if (d_pout[0] !== 8'h00 || d_pv[0] !== 1'b0 || d_cnt[0] !== 3'd0 || d_ov[0] !== 1'b0) begin
      bad++; $display("FAIL reset_init: got pout=%h pv=%b cnt=%0d ov=%b want all 0",
                      d_pout[0], d_pv[0], d_cnt[0], d_ov[0]);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_word(8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(i[0], 1'b1, 1'b0, 1'b0);
    total++;
    if (d_pv[0] !== 1'b1 || d_cnt[0] !== 3'd5) begin
      bad++; $display("FAIL reset_setup: got pv=%b cnt=%0d want pv=1 cnt=5", d_pv[0], d_cnt[0]);
    end
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (d_pout[k] !== 8'h00 || d_pv[k] !== 1'b0 || d_cnt[k] !== 3'd0 || d_ov[k] !== 1'b0) begin
        bad++; $display("FAIL reset_async[%0d]: got pout=%h pv=%b cnt=%0d ov=%b want all 0",
                        k, d_pout[k], d_pv[k], d_cnt[k], d_ov[k]);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step($urandom_range(0, 1), 1'b0, $urandom_range(0, 1), 1'b0);
      total++;
      if (d_pout[0] !== 8'h00 || d_pv[0] !== 1'b0 || d_cnt[0] !== 3'd0 || d_ov[0] !== 1'b0) begin
        bad++; $display("FAIL reset_idle cycle %0d: got pout=%h pv=%b cnt=%0d ov=%b want all 0",
                        c, d_pout[0], d_pv[0], d_cnt[0], d_ov[0]);
      end
    end
  endtask

  task automatic test_lsb_word();
    bit seq [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    for (int i = 0; i < W; i++) begin
      step(seq[i], 1'b1, 1'b0, 1'b0);
      if (i == W-2) begin
        total++;
        if (d_pv[0] !== 1'b0) begin
          bad++; $display("FAIL lsb_early_valid: got %b want 0", d_pv[0]);
        end
      end
    end
    total++;
    if (d_pout[0] !== 8'hA5 || d_pv[0] !== 1'b1 || d_cnt[0] !== 3'd0) begin
      bad++; $display("FAIL lsb_word: got pout=%h pv=%b cnt=%0d want A5/1/0",
                      d_pout[0], d_pv[0], d_cnt[0]);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (d_pv[0] !== 1'b0 || d_pout[0] !== 8'hA5) begin
      bad++; $display("FAIL lsb_consume: got pv=%b pout=%h want 0/A5", d_pv[0], d_pout[0]);
    end
  endtask

  task automatic test_msb_word();
    bit seq [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < W; i++) step(seq[i], 1'b1, 1'b0, 1'b0);
    total++;
    if (d_pout[1] !== 8'hC0 || d_pv[1] !== 1'b1) begin
      bad++; $display("FAIL msb_word: got pout=%h pv=%b want C0/1", d_pout[1], d_pv[1]);
    end
    total++;
    if (d_pout[0] !== 8'h03) begin
      bad++; $display("FAIL msb_vs_lsb: lsb instance got %h want 03", d_pout[0]);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    send_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (d_pout[0] !== 8'h3C || d_pv[0] !== 1'b1) begin
      bad++; $display("FAIL b2b_first: got pout=%h pv=%b want 3C/1", d_pout[0], d_pv[0]);
    end
    send_word(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (d_pout[0] !== 8'hFF || d_pv[0] !== 1'b1 || d_ov[0] !== 1'b0) begin
      bad++; $display("FAIL b2b_second: got pout=%h pv=%b ov=%b want FF/1/0",
                      d_pout[0], d_pv[0], d_ov[0]);
    end
    send_word(8'h5E, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (d_pout[k] !== m_pout[k] || d_pv[k] !== m_valid[k] || d_ov[k] !== 1'b0) begin
        bad++; $display("FAIL b2b_gapped[%0d]: got pout=%h pv=%b ov=%b want %h/%b/0",
                        k, d_pout[k], d_pv[k], d_ov[k], m_pout[k], m_valid[k]);
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    send_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (d_pout[0] !== 8'h11 || d_pv[0] !== 1'b1 || d_ov[0] !== 1'b1) begin
      bad++; $display("FAIL overrun_set: got pout=%h pv=%b ov=%b want 11/1/1",
                      d_pout[0], d_pv[0], d_ov[0]);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (d_cnt[0] !== 3'd3 || d_ov[0] !== 1'b1) begin
      bad++; $display("FAIL overrun_count: got cnt=%0d ov=%b want 3/1", d_cnt[0], d_ov[0]);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    total++;
    if (d_ov[0] !== 1'b0 || d_cnt[0] !== 3'd0 || d_pv[0] !== 1'b1 || d_pout[0] !== 8'h11) begin
      bad++; $display("FAIL overrun_clr: got ov=%b cnt=%0d pv=%b pout=%h want 0/0/1/11",
                      d_ov[0], d_cnt[0], d_pv[0], d_pout[0]);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_clr_align();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    total++;
    if (d_cnt[0] !== 3'd0 || d_cnt[1] !== 3'd0) begin
      bad++; $display("FAIL clr_cnt: got %0d/%0d want 0/0", d_cnt[0], d_cnt[1]);
    end
    send_word(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (d_pout[0] !== 8'h5A || d_pv[0] !== 1'b1) begin
      bad++; $display("FAIL clr_align_lsb: got pout=%h pv=%b want 5A/1", d_pout[0], d_pv[0]);
    end
    total++;
    if (d_pout[1] !== 8'h5A) begin
      bad++; $display("FAIL clr_align_msb: got pout=%h want 5A", d_pout[1]);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 1), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 60) == 0));
      for (int k = 0; k < 2; k++) begin
        total++;
        if (d_pout[k] !== m_pout[k] || d_pv[k] !== m_valid[k] || d_ov[k] !== m_ovr[k] ||
            d_cnt[k] !== CW'(q.size())) begin
          bad++; $display("FAIL random[%0d] cycle %0d: got pout=%h pv=%b ov=%b cnt=%0d want %h/%b/%b/%0d",
                          k, c, d_pout[k], d_pv[k], d_ov[k], d_cnt[k],
                          m_pout[k], m_valid[k], m_ovr[k], q.size());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_word();
    test_msb_word();
    test_back_to_back();
    test_overrun();
    test_clr_align();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
